// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial RAM port controller.
package mem_ctrl_pkg;

  // Access type encoding presented on mem_req_type.
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_TAIL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_e;

  // Number of byte beats an access needs.
  function automatic logic [2:0] nbytes_of(input mem_type_e t);
    case (t)
      MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
      MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
      default:                 return 3'd4;
    endcase
  endfunction

  function automatic logic is_store(input mem_type_e t);
    return (t == MEM_SB) || (t == MEM_SH) || (t == MEM_SW);
  endfunction

  // Encodings outside LB..SW (including NONE) never start a transfer.
  function automatic logic is_valid_type(input logic [3:0] t);
    return (t >= 4'd1) && (t <= 4'd8);
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM pin bundle between the pipeline stages, the
// controller and the byte-wide RAM.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  // Instruction fetch side
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic                  if_busy;
  logic                  if_done;
  logic [31:0]           if_data;
  // MEM stage side
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [31:0]           mem_req_data;
  logic [3:0]            mem_req_type;
  logic                  mem_busy;
  logic                  mem_done;
  logic [31:0]           mem_rdata;
  // RAM pins
  logic [ADDR_WIDTH-1:0] ram_a;
  logic [7:0]            ram_dout;
  logic [7:0]            ram_din;
  logic                  ram_wr;

  // Controller view
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_busy, if_done, if_data,
    input  mem_req, mem_req_addr, mem_req_data, mem_req_type,
    output mem_busy, mem_done, mem_rdata,
    output ram_a, ram_dout, ram_wr,
    input  ram_din
  );

  // Requester / RAM view
  modport master (
    output if_req, if_addr, if_flush,
    input  if_busy, if_done, if_data,
    output mem_req, mem_req_addr, mem_req_data, mem_req_type,
    input  mem_busy, mem_done, mem_rdata,
    input  ram_a, ram_dout, ram_wr,
    output ram_din
  );
endinterface

// File: rtl/mem_ctrl_ext.sv
// Load result extension: sign- or zero-extends the reassembled bytes.
module mem_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] rbuf,
  input  mem_type_e   mem_type,
  output logic [31:0] ext_data
);

  // Pick the extension by access type; words pass straight through.
  always_comb begin
    ext_data = rbuf;
    case (mem_type)
      MEM_LB:  ext_data = {{24{rbuf[7]}}, rbuf[7:0]};
      MEM_LBU: ext_data = {24'd0, rbuf[7:0]};
      MEM_LH:  ext_data = {{16{rbuf[15]}}, rbuf[15:0]};
      MEM_LHU: ext_data = {16'd0, rbuf[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetches and MEM accesses onto a single byte-wide RAM port,
// issuing one byte beat per cycle and reassembling loads.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter bit MEM_PRIO   = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  state_e                state_q, state_d;
  owner_e                owner_q;
  mem_type_e             type_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [2:0]            cnt_q, nbytes_q;
  logic [31:0]           wdata_q, rbuf_q;
  logic [31:0]           if_data_q, mem_rdata_q, ext_data;

  logic       if_ok, mem_ok;
  logic       accept_if, accept_mem;
  logic       store_q, last_beat, if_kill;
  logic [2:0] cnt_m1, nb_m1;

  // A flushed fetch never competes; MEM_NONE never competes.
  assign if_ok     = bus.if_req && !bus.if_flush;
  assign mem_ok    = bus.mem_req && is_valid_type(bus.mem_req_type);
  assign store_q   = is_store(type_q);
  assign last_beat = (cnt_q == nbytes_q - 3'd1);
  assign cnt_m1    = cnt_q - 3'd1;
  assign nb_m1     = nbytes_q - 3'd1;
  // Branch redirect kills only a fetch that is already under way.
  assign if_kill   = (owner_q == OWNER_IF) && bus.if_flush;

  mem_ext u_ext (
    .rbuf     (rbuf_q),
    .mem_type (type_q),
    .ext_data (ext_data)
  );

  assign bus.if_busy  = (state_q != ST_IDLE);
  assign bus.mem_busy = (state_q != ST_IDLE);
  // Results are visible in the done cycle and then held in registers.
  assign bus.if_data   = bus.if_done ? ext_data : if_data_q;
  assign bus.mem_rdata = (bus.mem_done && !store_q) ? ext_data : mem_rdata_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, arbitration and RAM pin decode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    accept_if    = 1'b0;
    accept_mem   = 1'b0;
    bus.ram_a    = '0;
    bus.ram_dout = '0;
    bus.ram_wr   = 1'b0;
    bus.if_done  = 1'b0;
    bus.mem_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_ok && (MEM_PRIO || !if_ok)) accept_mem = 1'b1;
        else if (if_ok)                     accept_if  = 1'b1;
        if (accept_mem || accept_if) state_d = ST_XFER;
      end
      ST_XFER: begin
        bus.ram_a = base_q + ADDR_WIDTH'(cnt_q);
        if (store_q) begin
          bus.ram_wr   = 1'b1;
          bus.ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end
        if (last_beat) state_d = store_q ? ST_DONE : ST_TAIL;
      end
      ST_TAIL: state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        if (owner_q == OWNER_MEM) bus.mem_done = 1'b1;
        else if (!bus.if_flush)   bus.if_done  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (if_kill && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Transfer context, byte collection and result holding registers.
  always_ff @(posedge clk) begin
    // NOTE: the context and read buffer are reset too so that every output
    // (including held load data) is a known zero straight out of reset.
    if (rst) begin
      base_q      <= '0;
      type_q      <= MEM_NONE;
      owner_q     <= OWNER_IF;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (accept_mem) begin
        base_q   <= bus.mem_req_addr;
        type_q   <= mem_type_e'(bus.mem_req_type);
        owner_q  <= OWNER_MEM;
        cnt_q    <= '0;
        nbytes_q <= nbytes_of(mem_type_e'(bus.mem_req_type));
        wdata_q  <= bus.mem_req_data;
        rbuf_q   <= '0;
      end else if (accept_if) begin
        base_q   <= bus.if_addr;
        type_q   <= MEM_LW;
        owner_q  <= OWNER_IF;
        cnt_q    <= '0;
        nbytes_q <= 3'd4;
        wdata_q  <= '0;
        rbuf_q   <= '0;
      end
      if (state_q == ST_XFER) begin
        cnt_q <= cnt_q + 3'd1;
        // RAM read data lags the address by one cycle.
        if (!store_q && (cnt_q != 3'd0))
          rbuf_q[{cnt_m1[1:0], 3'b000} +: 8] <= bus.ram_din;
      end
      if (state_q == ST_TAIL)
        rbuf_q[{nb_m1[1:0], 3'b000} +: 8] <= bus.ram_din;
      if (bus.if_done)              if_data_q   <= ext_data;
      if (bus.mem_done && !store_q) mem_rdata_q <= ext_data;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, hand-written
// arbitration/flush/reset sequences and randomized traffic against a
// byte-array reference model.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  mem_ctrl #(.ADDR_WIDTH(32), .MEM_PRIO(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Device RAM (driven by the DUT) and reference RAM (driven by the model).
  // Addresses used are 0..0x3FF and 0xFFFFFC00..0xFFFFFFFF.
  logic [7:0] dev_mem [0:2047];
  logic [7:0] ref_mem [0:2047];

  function automatic logic [10:0] idx(input logic [31:0] a);
    return {a[31], a[9:0]};
  endfunction

  // Synchronous byte RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    bus.ram_din <= dev_mem[idx(bus.ram_a)];
    if (bus.ram_wr) dev_mem[idx(bus.ram_a)] <= bus.ram_dout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    dev_mem[idx(a)] = b;
    ref_mem[idx(a)] = b;
  endtask

  // ---------------- reference model ----------------
  function automatic int nb(input logic [3:0] t);
    if (t == 4'd1 || t == 4'd4 || t == 4'd6) return 1;
    if (t == 4'd2 || t == 4'd5 || t == 4'd7) return 2;
    return 4;
  endfunction

  function automatic bit st_type(input logic [3:0] t);
    return t >= 4'd6;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] t, input logic [31:0] a);
    logic [31:0] v = 32'd0;
    logic [31:0] ai;
    for (int i = 0; i < nb(t); i++) begin
      ai = a + i;
      v  = v + (32'(ref_mem[idx(ai)]) << (8 * i));
    end
    if (t == 4'd1 && v >= 32'd128)   v = v - 32'd256;
    if (t == 4'd2 && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  task automatic model_store(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                             input int nbeats);
    logic [31:0] ai;
    for (int i = 0; i < nbeats && i < nb(t); i++) begin
      ai = a + i;
      ref_mem[idx(ai)] = 8'(d >> (8 * i));
    end
  endtask

  // ---------------- transaction drivers ----------------
  // One MEM access; checks beats, latency and done-pulse width, returns rdata.
  task automatic do_mem(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                        input string tag, output logic [31:0] rd);
    int  n   = nb(t);
    bit  st  = st_type(t);
    int  lat = -1;
    bit  done = 1'b0;
    logic [31:0] ea;
    rd = 32'hx;
    bus.mem_req = 1'b1; bus.mem_req_type = t; bus.mem_req_addr = a; bus.mem_req_data = d;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(posedge clk); #1;
      if (k - 1 < n) begin
        ea = a + (k - 1);
        check({tag, " ram_a"}, bus.ram_a, ea);
        check({tag, " ram_wr"}, {31'd0, bus.ram_wr}, {31'd0, st});
        if (st) check({tag, " ram_dout"}, {24'd0, bus.ram_dout}, {24'd0, 8'(d >> (8 * (k - 1)))});
      end else begin
        check({tag, " ram_wr idle"}, {31'd0, bus.ram_wr}, 32'd0);
      end
      if (bus.mem_done) begin
        done = 1'b1;
        lat  = k - 1;
        rd   = bus.mem_rdata;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(st ? n : n + 1));
    bus.mem_req = 1'b0;
    if (st) model_store(t, a, d, 4);
    @(posedge clk); #1;
    check({tag, " done pulse"}, {31'd0, bus.mem_done}, 32'd0);
    check({tag, " busy after"}, {31'd0, bus.mem_busy}, 32'd0);
  endtask

  task automatic do_if(input logic [31:0] a, input string tag, output logic [31:0] rd);
    int  lat = -1;
    bit  done = 1'b0;
    logic [31:0] exp = model_load(4'd3, a);
    rd = 32'hx;
    bus.if_req = 1'b1; bus.if_addr = a;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(posedge clk); #1;
      check({tag, " if ram_wr"}, {31'd0, bus.ram_wr}, 32'd0);
      if (bus.if_done) begin
        done = 1'b1;
        lat  = k - 1;
        rd   = bus.if_data;
      end
    end
    check({tag, " if latency"}, 32'(lat), 32'd5);
    check({tag, " if_data model"}, rd, exp);
    bus.if_req = 1'b0;
    @(posedge clk); #1;
    check({tag, " if_done pulse"}, {31'd0, bus.if_done}, 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, held;
    int mem_cnt, if_cnt, mem_t, if_t;
    bit if_seen;

    for (int i = 0; i < 2048; i++) preload(32'(i) | (i >= 1024 ? 32'hFFFFF800 : 32'd0), 8'd0);
    preload(32'h100, 8'h11); preload(32'h101, 8'h22); preload(32'h102, 8'h33); preload(32'h103, 8'h84);
    preload(32'h007, 8'h80);
    preload(32'h010, 8'h34); preload(32'h011, 8'hF2);
    preload(32'h040, 8'h78); preload(32'h041, 8'h56); preload(32'h042, 8'h34); preload(32'h043, 8'h12);

    vecs[0]  = '{4'd3, 32'h100,      32'h0,        32'h84332211};
    vecs[1]  = '{4'd1, 32'h007,      32'h0,        32'hFFFFFF80};
    vecs[2]  = '{4'd4, 32'h007,      32'h0,        32'h00000080};
    vecs[3]  = '{4'd2, 32'h010,      32'h0,        32'hFFFFF234};
    vecs[4]  = '{4'd5, 32'h010,      32'h0,        32'h0000F234};
    vecs[5]  = '{4'd8, 32'h200,      32'hDEADBEEF, 32'h0};
    vecs[6]  = '{4'd3, 32'h200,      32'h0,        32'hDEADBEEF};
    vecs[7]  = '{4'd7, 32'h300,      32'h1234ABCD, 32'h0};
    vecs[8]  = '{4'd3, 32'h300,      32'h0,        32'h0000ABCD};
    vecs[9]  = '{4'd6, 32'h301,      32'h00000055, 32'h0};
    vecs[10] = '{4'd5, 32'h300,      32'h0,        32'h000055CD};
    vecs[11] = '{4'd8, 32'hFFFFFFFE, 32'hCAFEF00D, 32'h0};
    vecs[12] = '{4'd3, 32'hFFFFFFFE, 32'h0,        32'hCAFEF00D};
    vecs[13] = '{4'd1, 32'h000,      32'h0,        32'hFFFFFFFE};

    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_req_addr = '0; bus.mem_req_data = '0; bus.mem_req_type = 4'd0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",      {30'd0, bus.if_busy, bus.mem_busy}, 32'd0);
    check("reset done",      {30'd0, bus.if_done, bus.mem_done}, 32'd0);
    check("reset ram_wr",    {31'd0, bus.ram_wr}, 32'd0);
    check("reset ram_a",     bus.ram_a, 32'd0);
    check("reset mem_rdata", bus.mem_rdata, 32'd0);
    check("reset if_data",   bus.if_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i]) begin
      do_mem(vecs[i].t, vecs[i].a, vecs[i].d, $sformatf("vec%0d", i), rd);
      if (!st_type(vecs[i].t)) begin
        check($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
        check($sformatf("vec%0d model", i), rd, model_load(vecs[i].t, vecs[i].a));
      end
    end

    // Load result holds across idle cycles
    held = bus.mem_rdata;
    repeat (3) @(posedge clk);
    #1;
    check("rdata hold", bus.mem_rdata, 32'hFFFFFFFE);

    // MEM_NONE request and flushed fetch are both ignored in IDLE
    bus.mem_req = 1'b1; bus.mem_req_type = 4'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("none ignored", {31'd0, bus.mem_busy}, 32'd0);
    end
    bus.mem_req = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.if_flush = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("flushed fetch ignored", {31'd0, bus.if_busy}, 32'd0);
    end

    // MEM accepted while if_flush is high; flush does not disturb it
    do_mem(4'd1, 32'h007, 32'h0, "mem+flush", rd);
    check("mem+flush rdata", rd, 32'hFFFFFF80);
    bus.if_req = 1'b0; bus.if_flush = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests: MEM first, IF right after, one done each
    bus.mem_req = 1'b1; bus.mem_req_type = 4'd3; bus.mem_req_addr = 32'h100;
    bus.if_req  = 1'b1; bus.if_addr = 32'h010;
    mem_cnt = 0; if_cnt = 0; mem_t = -1; if_t = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bus.mem_done) begin
        mem_cnt++; mem_t = k;
        check("arb mem_rdata", bus.mem_rdata, 32'h84332211);
        bus.mem_req = 1'b0;
      end
      if (bus.if_done) begin
        if_cnt++; if_t = k;
        check("arb if_data", bus.if_data, 32'h0000F234);
        bus.if_req = 1'b0;
      end
    end
    check("arb mem_done count", 32'(mem_cnt), 32'd1);
    check("arb if_done count",  32'(if_cnt),  32'd1);
    check("arb mem_done time",  32'(mem_t),   32'd6);
    check("arb if_done time",   32'(if_t),    32'(mem_t + 7));

    // Flush at A+2 of a fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    if_seen = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (bus.if_done) if_seen = 1'b1;
      if (k == 3) begin
        bus.if_flush = 1'b1; bus.if_req = 1'b0;
      end
      if (k == 4) begin
        check("flush idle", {31'd0, bus.if_busy}, 32'd0);
        bus.if_flush = 1'b0;
      end
    end
    check("flush no if_done", {31'd0, if_seen}, 32'd0);
    do_if(32'h040, "refetch", rd);
    check("refetch word", rd, 32'h12345678);

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  t;
      logic [31:0] a, d;
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + $urandom_range(0, 15))
                                      : 32'($urandom_range(0, 32'h3F0));
      d = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        do_if(a, $sformatf("rnd%0d", n), rd);
      end else begin
        t = 4'($urandom_range(1, 8));
        do_mem(t, a, d, $sformatf("rnd%0d", n), rd);
        if (!st_type(t)) check($sformatf("rnd%0d rdata", n), rd, model_load(t, a));
      end
    end

    // Reset at A+2 of a wrapping store
    bus.mem_req = 1'b1; bus.mem_req_type = 4'd8; bus.mem_req_addr = 32'hFFFFFFFE;
    bus.mem_req_data = 32'h01020304;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
    end
    check("pre-reset ram_a wrap", bus.ram_a, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    model_store(4'd8, 32'hFFFFFFFE, 32'h01020304, 3);
    check("midrst ram_wr",    {31'd0, bus.ram_wr}, 32'd0);
    check("midrst busy",      {30'd0, bus.if_busy, bus.mem_busy}, 32'd0);
    check("midrst done",      {30'd0, bus.if_done, bus.mem_done}, 32'd0);
    check("midrst ram_a",     bus.ram_a, 32'd0);
    check("midrst ram_dout",  {24'd0, bus.ram_dout}, 32'd0);
    check("midrst mem_rdata", bus.mem_rdata, 32'd0);
    check("midrst if_data",   bus.if_data, 32'd0);
    bus.mem_req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    do_mem(4'd3, 32'hFFFFFFFE, 32'h0, "post-reset", rd);
    check("post-reset rdata", rd, model_load(4'd3, 32'hFFFFFFFE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
